// File: rtl/aes_inv_round_pkg.sv
// Shared types, tables and GF(2^8) helpers for the inverse AES round slice.
//   state_t        : 16-byte cipher state, byte0 in bits [127:120], column-major
//   fsm_t          : round-engine states IDLE, SUB, MIX, DONE
//   INV_SBOX       : inverse S-box lookup table
//   xtime, gf_mul  : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11B)
//   inv_mix_column : InvMixColumns on one 32-bit column (byte0 in [31:24])
package aes_pkg;

    typedef logic [0:15][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round_if.sv
// Block-in / block-out handshake bundle for aes_inv_round.
//   in_valid/in_ready   : input block handshake; in_state, in_key, in_last qualify it
//   out_valid/out_ready : result handshake; out_state qualifies it
//   master : producer/consumer side (testbench or upstream logic)
//   slave  : round engine side
interface aes_inv_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_key, in_last, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/aes_inv_round_sbox.sv
// Combinational AES inverse S-box lookup.
//   din  : input byte
//   dout : InvSubBytes(din)
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = INV_SBOX[din];
endmodule

// File: rtl/aes_inv_round.sv
// One AES decryption round, column-serial:
//   InvShiftRows at accept, then InvSubBytes + AddRoundKey one column per
//   clock through four inverse S-boxes, then optionally InvMixColumns on the
//   whole state in one clock. Latency 4 edges, or 5 when InvMixColumns runs.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : aes_inv_round_if.slave (in_* and out_* handshakes)
// Build option: AES_INV_MIXCOL_EN enables the MIX state and honours in_last;
// without it every block takes the final-round path and in_last is ignored.
// Registers are cleared when the result is taken so no key/state remains.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    aes_inv_round_if.slave bus
);
    fsm_t       fsm;
    state_t     st;
    state_t     key;
    state_t     out_q;
    logic [1:0] col_cnt;

    state_t     in_s;
    state_t     isr;
    state_t     sub_st;
    logic [7:0] sb_in  [4];
    logic [7:0] sb_out [4];

    assign in_s = bus.in_state;

    // InvShiftRows: row r rotates right by r, out[r][c] = in[r][(c-r) mod 4]
    always_comb begin
        isr = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                isr[4*c + r] = in_s[4*((c + 4 - r) % 4) + r];
    end

    always_comb begin
        for (int unsigned r = 0; r < 4; r++)
            sb_in[r] = st[{col_cnt, 2'(r)}];
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        inv_sbox u_sbox (
            .din  (sb_in[g]),
            .dout (sb_out[g])
        );
    end

    // State with the current column replaced by its substituted, keyed bytes
    always_comb begin
        sub_st = st;
        for (int unsigned r = 0; r < 4; r++)
            sub_st[{col_cnt, 2'(r)}] = sb_out[r] ^ key[{col_cnt, 2'(r)}];
    end

`ifdef AES_INV_MIXCOL_EN
    logic   last;
    state_t mix_st;

    always_comb begin
        mix_st = '0;
        for (int unsigned c = 0; c < 4; c++)
            {mix_st[4*c], mix_st[4*c+1], mix_st[4*c+2], mix_st[4*c+3]} =
                inv_mix_column({st[4*c], st[4*c+1], st[4*c+2], st[4*c+3]});
    end
`else
    logic unused_last;
    assign unused_last = bus.in_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            st      <= '0;
            key     <= '0;
            out_q   <= '0;
            col_cnt <= '0;
`ifdef AES_INV_MIXCOL_EN
            last    <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        st      <= isr;
                        key     <= bus.in_key;
                        col_cnt <= '0;
`ifdef AES_INV_MIXCOL_EN
                        last    <= bus.in_last;
`endif
                        fsm     <= SUB;
                    end
                end
                SUB: begin
                    st      <= sub_st;
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
`ifdef AES_INV_MIXCOL_EN
                        if (last) begin
                            out_q <= sub_st;
                            fsm   <= DONE;
                        end else begin
                            fsm   <= MIX;
                        end
`else
                        out_q <= sub_st;
                        fsm   <= DONE;
`endif
                    end
                end
`ifdef AES_INV_MIXCOL_EN
                MIX: begin
                    out_q <= mix_st;
                    fsm   <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        st      <= '0;
                        key     <= '0;
                        out_q   <= '0;
                        col_cnt <= '0;
`ifdef AES_INV_MIXCOL_EN
                        last    <= 1'b0;
`endif
                        fsm     <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (fsm == IDLE);
    assign bus.out_valid = (fsm == DONE);
    assign bus.out_state = out_q;
endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard testbench for aes_inv_round. The reference model derives the
// inverse S-box from GF(2^8) inversion plus the affine map and applies the
// inverse round with byte arrays; the driver pushes expected results and a
// negedge monitor pops and compares them.
module tb_aes_inv_round;
`ifdef AES_INV_MIXCOL_EN
    localparam bit MIXEN = 1'b1;
`else
    localparam bit MIXEN = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    bit   rdy_mode = 1'b1;
    logic rdy_val = 1'b0;
    bit   seen = 1'b0;
    exp_t sb[$];

    logic [7:0] inv_tab [256];
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    aes_inv_round_if bus ();

    aes_inv_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Carry-less product, then long division by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic l);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m [16];
        logic [7:0] acc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = inv_tab[a[4*((c - r + 4) % 4) + r]] ^ k[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], b[4*c + j]);
                m[4*c + r] = (MIXEN && !l) ? acc : b[4*c + r];
            end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = m[i];
        return res;
    endfunction

    function automatic int lat_of(input logic l);
        return (MIXEN && !l) ? 5 : 4;
    endfunction

    // Entered at posedge+1; returns at posedge+1 two edges after acceptance
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                        input logic [127:0] exp, input int lat,
                        input bit isr_chk, input logic [127:0] isr_exp);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_key   = k;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) begin
            total++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
            return;
        end
        sb.push_back('{exp, lat, cyc + 1});
        @(posedge clk);
        #1;
        if (isr_chk) chk("inv_shift_rows", dut.st, isr_exp);
        // Junk offered while busy must be ignored
        bus.in_state = {4{$urandom}};
        bus.in_key   = {4{$urandom}};
        bus.in_last  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got %h with no block outstanding, required none", bus.out_state);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 128'(cyc - sb[0].acc), 128'(sb[0].lat));
                end
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    chk("out_state", bus.out_state, e.data);
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] fwd [256];
        logic [7:0] inv, y;
        logic [127:0] s, k, held;
        logic l;
        int n;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int q = 1; q < 256; q++)
                if (x != 0 && gmul(8'(x), 8'(q)) == 8'h01) inv = 8'(q);
            y = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            fwd[x] = y;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd[x]] = 8'(x);

        bus.in_valid = 1'b0;
        bus.in_state = '0;
        bus.in_key   = '0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_out_state", bus.out_state, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));

        send({16{8'h63}}, '0, 1'b0, '0, lat_of(1'b0), 1'b0, '0);
        send({16{8'h00}}, '0, 1'b0, {16{8'h52}}, lat_of(1'b0), 1'b0, '0);
        send({16{8'h00}}, '0, 1'b1, {16{8'h52}}, 4, 1'b0, '0);
        send({16{8'h00}}, {16{8'h52}}, 1'b1, '0, 4, 1'b0, '0);
        s = 128'h00112233445566778899aabbccddeeff;
        send(s, '0, 1'b1, model(s, '0, 1'b1), 4, 1'b1, 128'h00ddaa774411eebb885522ffcc996633);

        for (int i = 0; i < 40; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom_range(0, 1));
            send(s, k, l, model(s, k, l), lat_of(l), 1'b0, '0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Stall in DONE, then check zeroization on the release edge
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        rdy_mode = 1'b0;
        rdy_val  = 1'b0;
        @(posedge clk);
        #1;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0, model(s, k, 1'b0), lat_of(1'b0), 1'b0, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        chk("stall_reached_done", 128'(bus.out_valid), 128'(1));
        held = bus.out_state;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_state", bus.out_state, held);
            chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
        end
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("release_in_ready", 128'(bus.in_ready), 128'(1));
        chk("zero_state", dut.st, '0);
        chk("zero_key", dut.key, '0);
        chk("zero_out_state", bus.out_state, '0);
        rdy_mode = 1'b1;

        // Abort mid-SUB with col_cnt = 2
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, '1, 1'b1, model(s, '1, 1'b1), 4, 1'b0, '0);
        chk("abort_col_cnt", 128'(dut.col_cnt), 128'(2));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_out_state", bus.out_state, '0);
        chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
        chk("abort_state", dut.st, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0, model(s, k, 1'b0), lat_of(1'b0), 1'b0, '0);

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_inv_round.md
AES_INV_ROUND -- requirements
Module: aes_inv_round

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  in  1  input block offered.
REQ-004 SHALL have port: in_ready  out  1  block accepted when in_valid && in_ready at a rising edge.
REQ-005 SHALL have port: in_state  in  128  cipher state; byte0 = [127:120], column-major (FIPS-197).
REQ-006 SHALL have port: in_key  in  128  round key, same byte order.
REQ-007 SHALL have port: in_last  in  1  final inverse round, so InvMixColumns is skipped.
REQ-008 SHALL have port: out_valid  out  1  result available.
REQ-009 SHALL have port: out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.
REQ-010 SHALL have port: out_state  out  128  round result, same byte order.

Function
REQ-011 SHALL compute out = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(in_state)), in_key)); InvMixColumns omitted when in_last=1.
REQ-012 SHALL implement InvShiftRows as out[r][c] = in[r][(c-r) mod 4], r,c in 0..3.
REQ-013 SHALL have FSM states IDLE, SUB, MIX, DONE, with exactly these transitions.
REQ-014 IDLE: in_ready=1; on accept (edge E0), latch InvShiftRows(in_state), in_key, in_last; col_cnt=0; go to SUB.
REQ-015 SUB: one column per edge (E1..E4) through 4 inv_sbox instances, XORed with the key column; col_cnt 0..3; after col 3, go to MIX if last=0, else go to DONE.
REQ-016 MIX: apply InvMixColumns to all 4 columns in one edge (E5); go to DONE.
REQ-017 SHALL assert out_valid in the cycle after E5 (last=0) or after E4 (last=1); latency 5 or 4 edges from acceptance.
REQ-018 DONE: out_valid=1; out_state SHALL remain stable until out_valid && out_ready; then go to IDLE.
REQ-019 in_ready SHALL be 0 in SUB, MIX and DONE; in_valid there SHALL be ignored; no same-cycle accept on leaving DONE.
REQ-020 Zeroization: on the DONE-to-IDLE edge, state, key and out_state registers SHALL clear to 0.
REQ-021 out_ready held high before DONE SHALL have no effect; out_ready low SHALL stall in DONE indefinitely.
REQ-022 GF(2^8) arithmetic SHALL use the reduction polynomial 0x11B; InvMixColumns coefficients are 0e,0b,0d,09.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, col_cnt=0 and all data registers to 0; out_valid=0; out_state=0; in_ready=1 after the first edge with rst_n=1.
REQ-024 A reset during SUB, MIX or DONE SHALL abort the block with no output and no partial data left.

Configuration
REQ-025 Macro AES_INV_MIXCOL_EN: when defined, REQ-011, REQ-015 and REQ-016 apply as written.
REQ-026 Without AES_INV_MIXCOL_EN: MIX state and InvMixColumns logic absent; in_last ignored; every block takes the last=1 path (latency 4).

Structure
REQ-027 Package aes_pkg SHALL hold: state_t (16x8 byte array), FSM state enum, the INV_SBOX table, and functions xtime, gf_mul and inv_mix_column.
REQ-028 Sub-module inv_sbox (8-bit in, 8-bit out, combinational) SHALL be the only sub-module; 4 instances.

Verification
REQ-029 in_state=all 63, key=0, last=0 -> out_state=0, out_valid after E5.
REQ-030 in_state=all 00, key=0, last=0 -> out_state=all 52; last=1 -> all 52 after E4.
REQ-031 in_state=all 00, key=all 52, last=1 -> out_state=0; confirms AddRoundKey.
REQ-032 InvShiftRows check: inverse S-box bypassed via a bench force; in_state=00112233445566778899aabbccddeeff -> 00ddaa774411eebb885522ffcc996633.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0; then out_ready=1 -> IDLE next cycle, internal registers 0.
REQ-034 Assert rst_n=0 during SUB with col_cnt=2 -> next cycle IDLE, out_valid=0, out_state=0; a following block completes correctly.
